// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register "none" marker and the
// fetch state encoding used by the sequential and (future) pipelined fetch stages.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational Y86-64 first-byte decode: instruction length, which optional
// fields follow, where valC starts, and whether the icode/ifun pair is legal.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ifun,
    output logic [3:0] o_length,
    output logic       o_need_regids,
    output logic       o_need_valc,
    output logic [3:0] o_valc_offset,
    output logic       o_legal
);

    always_comb begin
        o_length      = 4'd1;
        o_need_regids = 1'b0;
        o_need_valc   = 1'b0;
        o_valc_offset = 4'd0;
        o_legal       = 1'b0;
        case (i_icode)
            IHALT, INOP, IRET: begin
                o_legal = (i_ifun == 4'd0);
            end
            IRRMOVQ: begin
                o_length      = 4'd2;
                o_need_regids = 1'b1;
                o_legal       = (i_ifun <= 4'd6);
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                o_length      = 4'd10;
                o_need_regids = 1'b1;
                o_need_valc   = 1'b1;
                o_valc_offset = 4'd2;
                o_legal       = (i_ifun == 4'd0);
            end
            IOPQ: begin
                o_length      = 4'd2;
                o_need_regids = 1'b1;
                o_legal       = (i_ifun <= 4'd3);
            end
            IJXX: begin
                o_length      = 4'd9;
                o_need_valc   = 1'b1;
                o_valc_offset = 4'd1;
                o_legal       = (i_ifun <= 4'd6);
            end
            ICALL: begin
                o_length      = 4'd9;
                o_need_valc   = 1'b1;
                o_valc_offset = 4'd1;
                o_legal       = (i_ifun == 4'd0);
            end
            IPUSHQ, IPOPQ: begin
                o_length      = 4'd2;
                o_need_regids = 1'b1;
                o_legal       = (i_ifun == 4'd0);
            end
            default: begin
                o_length = 4'd1;
                o_legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial Y86-64 fetch: reads one instruction byte per memory ack starting
// at PC, assembles icode/ifun/rA/rB/valC and reports valP and error status.
module fetch_unit
    import y86_pkg::*;
#(
    parameter int unsigned MAX_LEN = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    localparam int unsigned CntW = $clog2(MAX_LEN + 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;

    logic [63:0]   r_pc;
    logic [CntW-1:0] r_count;
    logic [3:0]    r_icode;
    logic [3:0]    r_ifun;
    logic [3:0]    r_ra;
    logic [3:0]    r_rb;
    logic [63:0]   r_valc;
    logic [63:0]   r_valp;
    logic          r_instr_valid;
    logic          r_imem_error;

    logic [3:0]    w_dec_icode;
    logic [3:0]    w_dec_ifun;
    logic [3:0]    w_len;
    logic          w_need_regids;
    logic          w_need_valc;
    logic [3:0]    w_valc_off;
    logic          w_legal;

    logic          w_fetching;
    logic          w_accept;
    logic          w_err;
    logic          w_last;
    logic          w_in_valc;
    logic [2:0]    w_vbyte;
    logic [CntW-1:0] w_count_inc;

    // Byte 0 is decoded straight off the bus so a 1-byte instruction can finish on it.
    assign w_dec_icode = (r_count == '0) ? mem_rdata[7:4] : r_icode;
    assign w_dec_ifun  = (r_count == '0) ? mem_rdata[3:0] : r_ifun;

    instr_len_decode u_len_decode (
        .i_icode       (w_dec_icode),
        .i_ifun        (w_dec_ifun),
        .o_length      (w_len),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_valc_offset (w_valc_off),
        .o_legal       (w_legal)
    );

    assign w_fetching  = (r_state == StFetch);
    assign w_accept    = w_fetching && mem_ack && !mem_err;
    assign w_err       = w_fetching && mem_ack && mem_err;
    assign w_count_inc = r_count + CntW'(1);
    assign w_last      = w_accept && (w_count_inc == CntW'(w_len));
    assign w_in_valc   = w_need_valc && (r_count >= CntW'(w_valc_off));
    assign w_vbyte     = 3'(r_count - CntW'(w_valc_off));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (start) w_state_nxt = StFetch;
            StFetch: if (w_last || w_err) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_count       <= '0;
            r_icode       <= IHALT;
            r_ifun        <= 4'd0;
            r_ra          <= REG_NONE;
            r_rb          <= REG_NONE;
            r_valc        <= '0;
            r_valp        <= '0;
            r_instr_valid <= 1'b0;
            r_imem_error  <= 1'b0;
        end else if ((r_state == StIdle) && start) begin
            r_pc          <= PC;
            r_count       <= '0;
            r_icode       <= IHALT;
            r_ifun        <= 4'd0;
            r_ra          <= REG_NONE;
            r_rb          <= REG_NONE;
            r_valc        <= '0;
            r_valp        <= '0;
            r_instr_valid <= 1'b0;
            r_imem_error  <= 1'b0;
        end else if (w_err) begin
            // The faulting byte is not counted: valP reflects only accepted bytes.
            r_imem_error  <= 1'b1;
            r_instr_valid <= 1'b0;
            r_valp        <= r_pc + 64'(r_count);
        end else if (w_accept) begin
            r_count <= w_count_inc;
            if (r_count == '0) begin
                r_icode <= mem_rdata[7:4];
                r_ifun  <= mem_rdata[3:0];
            end
            if (w_need_regids && (r_count == CntW'(1))) begin
                r_ra <= mem_rdata[7:4];
                r_rb <= mem_rdata[3:0];
            end
            if (w_in_valc) begin
                r_valc[{w_vbyte, 3'b000} +: 8] <= mem_rdata;
            end
            if (w_last) begin
                r_valp        <= r_pc + 64'(w_count_inc);
                r_instr_valid <= w_legal;
            end
        end
    end

    assign mem_req     = w_fetching;
    assign mem_addr    = w_fetching ? (r_pc + 64'(r_count)) : 64'd0;
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StDone);
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign rA          = r_ra;
    assign rB          = r_rb;
    assign valC        = r_valc;
    assign valP        = r_valp;
    assign instr_valid = r_instr_valid;
    assign imem_error  = r_imem_error;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small byte image serves the memory handshake
// and each scenario task checks its own results against hand-computed values.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] PC;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic        busy;
    logic        done;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  img [16];
    logic [63:0] img_base;

    always #5 clk = ~clk;

    fetch_unit #(.MAX_LEN(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .PC          (PC),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .busy        (busy),
        .done        (done),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error)
    );

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    // Pulses start at pc and serves bytes from img; returns cycles from start to done
    // (-1 if done never came) and whether mem_addr stayed put across wait cycles.
    task automatic run_fetch(input logic [63:0] pc, input bit alt, input int err_at,
                             output int done_cycle, output bit addr_hold);
        logic [63:0] prev_addr;
        bit          waited;
        int          accepted;
        done_cycle = -1;
        addr_hold  = 1'b1;
        waited     = 1'b0;
        accepted   = 0;
        prev_addr  = '0;
        img_base   = pc;
        @(negedge clk);
        PC    = pc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_cycle = i + 1;
                break;
            end
            mem_ack = 1'b0;
            mem_err = 1'b0;
            if (mem_req) begin
                if (alt && !waited) begin
                    waited    = 1'b1;
                    prev_addr = mem_addr;
                end else begin
                    if (waited && (mem_addr !== prev_addr)) addr_hold = 1'b0;
                    waited    = 1'b0;
                    mem_ack   = 1'b1;
                    mem_rdata = img[4'(mem_addr - img_base)];
                    mem_err   = (accepted == err_at);
                    accepted++;
                end
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, mem_req, instr_valid, imem_error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {busy, done, mem_req, instr_valid, imem_error});
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h00FF) begin
            n_fail++;
            $display("FAIL reset_fields got %h want 00ff", {icode, ifun, rA, rB});
        end
        n_tests++;
        if ({valC, valP, mem_addr} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_words got %h %h %h want 0", valC, valP, mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_irmovq();
        int dc;
        bit ah;
        logic [7:0] b [10] = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB,
                               8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        clear_img();
        for (int i = 0; i < 10; i++) img[i] = b[i];
        run_fetch(64'h100, 1'b0, -1, dc, ah);
        n_tests++;
        if (dc !== 11) begin
            n_fail++;
            $display("FAIL irmovq_latency got %0d want 11", dc);
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h30F3) begin
            n_fail++;
            $display("FAIL irmovq_fields got %h want 30f3", {icode, ifun, rA, rB});
        end
        n_tests++;
        if (valC !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("FAIL irmovq_valC got %h want 0123456789abcdef", valC);
        end
        n_tests++;
        if (valP !== 64'h10A || instr_valid !== 1'b1 || imem_error !== 1'b0) begin
            n_fail++;
            $display("FAIL irmovq_valP got %h v%b e%b want 10a v1 e0",
                     valP, instr_valid, imem_error);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || valP !== 64'h10A) begin
            n_fail++;
            $display("FAIL irmovq_pulse got done=%b busy=%b valP=%h want 0 0 10a",
                     done, busy, valP);
        end
    endtask

    task automatic test_jne_wait();
        int dc;
        bit ah;
        clear_img();
        img[0] = 8'h74;
        img[1] = 8'h40;
        run_fetch(64'h20, 1'b1, -1, dc, ah);
        n_tests++;
        if (dc !== 19) begin
            n_fail++;
            $display("FAIL jne_latency got %0d want 19", dc);
        end
        n_tests++;
        if (ah !== 1'b1) begin
            n_fail++;
            $display("FAIL jne_addr_hold got %b want 1", ah);
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h74FF || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL jne_fields got %h v%b want 74ff v1",
                     {icode, ifun, rA, rB}, instr_valid);
        end
        n_tests++;
        if (valC !== 64'h40 || valP !== 64'h29) begin
            n_fail++;
            $display("FAIL jne_vals got %h %h want 40 29", valC, valP);
        end
    endtask

    task automatic test_single_byte();
        int dc;
        bit ah;
        logic [63:0] pcs [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0500,
                                 64'h0000_0000_0000_0600};
        logic [7:0]  ops [3] = '{8'h90, 8'h00, 8'hC0};
        logic [63:0] vps [3] = '{64'h0, 64'h501, 64'h601};
        bit          vld [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            clear_img();
            img[0] = ops[k];
            run_fetch(pcs[k], 1'b0, -1, dc, ah);
            n_tests++;
            if (dc !== 2) begin
                n_fail++;
                $display("FAIL single%0d_latency got %0d want 2", k, dc);
            end
            n_tests++;
            if (valP !== vps[k] || instr_valid !== vld[k] || {icode, ifun} !== ops[k]) begin
                n_fail++;
                $display("FAIL single%0d_result got %h v%b op%h want %h v%b op%h",
                         k, valP, instr_valid, {icode, ifun}, vps[k], vld[k], ops[k]);
            end
        end
    endtask

    task automatic test_opq_bad_ifun();
        int dc;
        bit ah;
        clear_img();
        img[0] = 8'h65;
        img[1] = 8'h23;
        img[2] = 8'h77;
        run_fetch(64'h40, 1'b0, -1, dc, ah);
        n_tests++;
        if (dc !== 3 || valP !== 64'h42) begin
            n_fail++;
            $display("FAIL opq_len got cyc=%0d valP=%h want 3 42", dc, valP);
        end
        n_tests++;
        if (instr_valid !== 1'b0 || rA !== 4'h2 || rB !== 4'h3) begin
            n_fail++;
            $display("FAIL opq_fields got v%b rA=%h rB=%h want v0 2 3", instr_valid, rA, rB);
        end
    endtask

    task automatic test_mem_err();
        int dc;
        bit ah;
        clear_img();
        img[0] = 8'h40;
        img[1] = 8'h12;
        img[2] = 8'h08;
        img[3] = 8'h55;
        run_fetch(64'h200, 1'b0, 3, dc, ah);
        n_tests++;
        if (dc !== 5) begin
            n_fail++;
            $display("FAIL err_latency got %0d want 5", dc);
        end
        n_tests++;
        if (imem_error !== 1'b1 || instr_valid !== 1'b0 || valP !== 64'h203) begin
            n_fail++;
            $display("FAIL err_status got e%b v%b valP=%h want e1 v0 203",
                     imem_error, instr_valid, valP);
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h4012 || valC !== 64'h08) begin
            n_fail++;
            $display("FAIL err_fields got %h valC=%h want 4012 08", {icode, ifun, rA, rB}, valC);
        end
    endtask

    task automatic test_reset_abort();
        int dc;
        bit ah;
        bit saw_done;
        clear_img();
        img[0] = 8'h30;
        img[1] = 8'hF3;
        img[2] = 8'hAA;
        img_base = 64'h100;
        @(negedge clk);
        PC    = 64'h100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = img[4'(mem_addr - img_base)];
            @(negedge clk);
        end
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy, done, mem_req} !== 3'b000 || mem_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL abort_ctrl got %b addr=%h want 000 0", {busy, done, mem_req}, mem_addr);
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h00FF || valC !== 64'd0 || valP !== 64'd0) begin
            n_fail++;
            $display("FAIL abort_fields got %h %h %h want 00ff 0 0",
                     {icode, ifun, rA, rB}, valC, valP);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done got %b want 0", saw_done);
        end
        clear_img();
        img[0] = 8'h10;
        run_fetch(64'h300, 1'b0, -1, dc, ah);
        n_tests++;
        if (dc !== 2 || valP !== 64'h301 || instr_valid !== 1'b1 || icode !== 4'h1) begin
            n_fail++;
            $display("FAIL abort_refetch got cyc=%0d valP=%h v%b ic=%h want 2 301 v1 1",
                     dc, valP, instr_valid, icode);
        end
    endtask

    initial begin
        start     = 1'b0;
        PC        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_err   = 1'b0;
        img_base  = '0;
        test_reset();
        test_irmovq();
        test_jne_wait();
        test_single_byte();
        test_opq_bad_ifun();
        test_mem_err();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
